// File: rtl/rtx_uart_pkg.sv
// Shared constants for the host-bound telemetry link: framing bytes,
// packet type codes, packet lengths and the transmit FSM state type.
package rtx_uart_pkg;

    localparam logic [7:0] SYNC_BYTE  = 8'hA5;
    localparam logic [7:0] TYPE_ACK   = 8'h01;
    localparam logic [7:0] TYPE_FRAME = 8'h02;

    localparam int ACK_LEN   = 4;
    localparam int FRAME_LEN = 5;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_WAIT
    } tx_state_e;

    // Packet checksum: XOR of every byte that follows the sync byte.
    function automatic logic [7:0] pkt_chk(input logic [7:0] type_code,
                                           input logic [7:0] b0,
                                           input logic [7:0] b1);
        return type_code ^ b0 ^ b1;
    endfunction

endpackage

// File: rtl/uart_transmit.sv
// 8N1 UART byte serializer. Accepts one byte when ready, then drives
// start bit, d0..d7 LSB first and stop bit, each BAUD_DIV cycles long.
module uart_transmit #(
    parameter int CLK_HZ    = 100_000_000,
    parameter int BAUD_RATE = 115_200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] din,
    input  logic       din_valid,
    output logic       ready,
    output logic       txd
);

    localparam int BAUD_DIV = CLK_HZ / BAUD_RATE;
    localparam int CNT_W    = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_DIV - 1);

    logic             active;
    logic [CNT_W-1:0] baud_cnt;
    logic [3:0]       bit_idx;
    // Bits still to be sent after the current one; refilled with ones so
    // the stop bit falls out naturally after d7.
    logic [8:0]       shreg;

    assign ready = ~active;

    // Baud counter, bit counter and shift register; txd is registered so the
    // line never glitches and an abandoned byte leaves it high on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active   <= 1'b0;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shreg    <= '1;
            txd      <= 1'b1;
        end else if (!active) begin
            if (din_valid) begin
                active   <= 1'b1;
                baud_cnt <= '0;
                bit_idx  <= '0;
                shreg    <= {1'b1, din};
                txd      <= 1'b0;
            end
        end else if (baud_cnt == CNT_LAST) begin
            baud_cnt <= '0;
            if (bit_idx == 4'd9) begin
                active <= 1'b0;
            end else begin
                bit_idx <= bit_idx + 4'd1;
                txd     <= shreg[0];
                shreg   <= {1'b1, shreg[8:1]};
            end
        end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/uart_status_tx.sv
// Telemetry transmitter: latches ACK / FRAME events, builds framed packets
// with checksum and hands them byte by byte to the UART serializer.
module uart_status_tx
    import rtx_uart_pkg::*;
#(
    parameter int CLK_HZ    = 100_000_000,
    parameter int BAUD_RATE = 115_200
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ack_valid,
    input  logic [7:0]  ack_cmd,
    input  logic        frame_done,
    input  logic [15:0] frame_count,
    output logic        uart_txd,
    output logic        busy,
    output logic [7:0]  dropped_count
);

    tx_state_e       state;
    tx_state_e       state_next;
    logic            ack_pending;
    logic            frame_pending;
    logic [7:0]      ack_buf;
    logic [15:0]     frame_buf;
    logic            sel_ack;
    logic            sel_frame;
    logic            advance;
    logic            tx_valid;
    logic            tx_ready;
    // Snapshot of the packet in flight; byte 0 is the one being presented.
    logic [4:0][7:0] pkt;
    logic [2:0]      remaining;

    assign busy = ack_pending | frame_pending | (state != ST_IDLE);

    // Event latches. A pulse arriving in the cycle its flag is consumed is
    // kept; a second ACK on top of an unconsumed one is counted as dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ack_pending   <= 1'b0;
            ack_buf       <= '0;
            frame_pending <= 1'b0;
            frame_buf     <= '0;
            dropped_count <= '0;
        end else begin
            if (ack_valid) begin
                if (ack_pending && !sel_ack) begin
                    if (dropped_count != 8'hFF)
                        dropped_count <= dropped_count + 8'd1;
                end else begin
                    ack_pending <= 1'b1;
                    ack_buf     <= ack_cmd;
                end
            end else if (sel_ack) begin
                ack_pending <= 1'b0;
            end

            if (frame_done) begin
                frame_pending <= 1'b1;
                frame_buf     <= frame_count;
            end else if (sel_frame) begin
                frame_pending <= 1'b0;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    // Next-state and control: packet selection with ACK priority, byte
    // hand-off and end-of-packet detection.
    always_comb begin
        state_next = state;
        sel_ack    = 1'b0;
        sel_frame  = 1'b0;
        advance    = 1'b0;
        tx_valid   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (ack_pending) begin
                    sel_ack    = 1'b1;
                    state_next = ST_SEND;
                end else if (frame_pending) begin
                    sel_frame  = 1'b1;
                    state_next = ST_SEND;
                end
            end
            ST_SEND: begin
                tx_valid   = 1'b1;
                state_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (tx_ready) begin
                    if (remaining == 3'd0) begin
                        state_next = ST_IDLE;
                    end else begin
                        advance    = 1'b1;
                        state_next = ST_SEND;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Packet snapshot at selection, then one-byte shift per completed byte.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pkt       <= '0;
            remaining <= '0;
        end else if (sel_ack) begin
            pkt       <= {8'h00, pkt_chk(TYPE_ACK, ack_buf, 8'h00), ack_buf,
                          TYPE_ACK, SYNC_BYTE};
            remaining <= 3'(ACK_LEN - 1);
        end else if (sel_frame) begin
            pkt       <= {pkt_chk(TYPE_FRAME, frame_buf[15:8], frame_buf[7:0]),
                          frame_buf[7:0], frame_buf[15:8], TYPE_FRAME, SYNC_BYTE};
            remaining <= 3'(FRAME_LEN - 1);
        end else if (advance) begin
            pkt       <= {8'h00, pkt[4:1]};
            remaining <= remaining - 3'd1;
        end
    end

    uart_transmit #(
        .CLK_HZ    (CLK_HZ),
        .BAUD_RATE (BAUD_RATE)
    ) u_tx (
        .clk       (clk),
        .rst       (rst),
        .din       (pkt[0]),
        .din_valid (tx_valid),
        .ready     (tx_ready),
        .txd       (uart_txd)
    );

endmodule
